jk_bank_arbiter: RTL

Shares one bank of WIDTH JK flip-flops between two requesters. Each requester presents per-bit J and K masks with a valid/ready handshake. A round-robin arbiter grants one requester per cycle and applies the winning masks to the bank at that clock edge. A lock option lets the granted requester hold the bank for an atomic multi-cycle sequence. The block sits between the control sequencers and the shared JK status/flag register.

---
 rtl/jk_bank_arbiter.sv | 63 ++++++
 1 files changed

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin/lockable arbiter sharing one JK flip-flop bank between two requesters
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_j,
  input  logic [WIDTH-1:0] req0_k,
  input  logic             req0_lock,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_j,
  input  logic [WIDTH-1:0] req1_k,
  input  logic             req1_lock,
  output logic             req1_ready,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       owner,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {FREE = 2'b00, LOCK0 = 2'b01, LOCK1 = 2'b10} own_e;
  own_e             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] q_q, q_d, j, k;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock0, lock1, free, g0, g1, acc, lk;
  // Grant decode and next-state: ptr_q=1 gives req1 priority; encoding 11 falls through to FREE
  always_comb begin
    lock0   = owner_q == LOCK0;
    lock1   = owner_q == LOCK1;
    free    = !lock0 && !lock1;
    g0      = !reset && req0_valid && (lock0 || (free && (!req1_valid || !ptr_q)));
    g1      = !reset && req1_valid && (lock1 || (free && (!req0_valid || ptr_q)));
    acc     = g0 || g1;
    j       = g1 ? req1_j : req0_j;
    k       = g1 ? req1_k : req0_k;
    lk      = g1 ? req1_lock : req0_lock;
    q_d     = acc ? (j & ~q_q) | (~k & q_q) : q_q;
    owner_d = !acc ? owner_q : !lk ? FREE : g1 ? LOCK1 : LOCK0;
    ptr_d   = (acc && free) ? g0 : ptr_q;
    cnt_d   = cnt_q + CNT_W'(acc);
  end
  // Registered bank, owner FSM, priority pointer and op counter; reset wins over any accept
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= '0;
      owner_q <= FREE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign q          = q_q;
  assign owner      = owner_q;
  assign op_count   = cnt_q;
endmodule
